// File: rtl/crank_if.sv
// crank_if: groups the raw crank input and the tooth-synchronous timing stream.
//   master modport: the decoder (samples crank_in, drives the timing stream).
//   slave modport:  the sensor side / consumers (drive crank_in, observe the stream).
//   crank_in              raw crank sensor input, asynchronous, active on rising edge
//   trigger               one-clock pulse per accepted tooth while synced
//   eng_phase             angle of the tooth just accepted, in quanta
//   next_tooth_width      quanta from this tooth to the next expected edge
//   tooth_period          clocks between the last two normal teeth
//   quanta_per_revolution constant quanta per wheel revolution
//   synced                high while locked to the wheel
//   sync_loss             one-clock pulse when lock is lost on a tooth-count error
interface crank_if;
   logic        crank_in;
   logic        trigger;
   logic [15:0] eng_phase;
   logic [15:0] next_tooth_width;
   logic [31:0] tooth_period;
   logic [15:0] quanta_per_revolution;
   logic        synced;
   logic        sync_loss;

   modport master (
      input  crank_in,
      output trigger,
      output eng_phase,
      output next_tooth_width,
      output tooth_period,
      output quanta_per_revolution,
      output synced,
      output sync_loss
   );

   modport slave (
      output crank_in,
      input  trigger,
      input  eng_phase,
      input  next_tooth_width,
      input  tooth_period,
      input  quanta_per_revolution,
      input  synced,
      input  sync_loss
   );
endinterface

// File: rtl/crank_decoder.sv
// crank_decoder: missing-tooth crank trigger-wheel decoder. Synchronises the raw crank
// input, rejects noise edges, finds the missing-tooth gap and emits a tooth-synchronous
// timing stream (trigger, phase, next tooth width, tooth period) for the output drivers.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    crank_if.master: crank_in in, timing stream out
module crank_decoder #(
   parameter int unsigned TEETH_TOTAL      = 36,
   parameter int unsigned TEETH_MISSING    = 1,
   parameter int unsigned QUANTA_PER_TOOTH = 10,
   parameter int unsigned MIN_PERIOD       = 16,
   parameter int unsigned STALL_CLKS       = 32'd50_000_000
) (
   input logic     clk,
   input logic     rst_n,
   crank_if.master bus
);

   localparam int unsigned PRESENT = TEETH_TOTAL - TEETH_MISSING;
   localparam logic [15:0] LAST_IDX  = 16'(PRESENT - 1);
   localparam logic [15:0] QPT       = 16'(QUANTA_PER_TOOTH);
   localparam logic [15:0] GAP_WIDTH = 16'((TEETH_MISSING + 1) * QUANTA_PER_TOOTH);
   localparam logic [15:0] QPR       = 16'(TEETH_TOTAL * QUANTA_PER_TOOTH);

   typedef enum logic [1:0] {
      StStalled,
      StPriming,
      StSeeking,
      StSynced
   } state_e;

   state_e      state_q, state_d;
   logic        sync1_q, sync2_q, prev_q;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] last_int_q, last_int_d;
   logic [31:0] period_q, period_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] phase_q, phase_d;
   logic [15:0] width_q, width_d;
   logic        trigger_q, trigger_d;
   logic        loss_q, loss_d;

   logic        edge_det;
   logic        stall;
   logic        accept;
   logic        gap;
   logic [32:0] gap_thresh;

   // Two-flop synchroniser plus one history flop for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= bus.crank_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_det = sync2_q & ~prev_q;

   // Once stalled, the saturated counter must not keep vetoing edges, otherwise the
   // wheel could never restart; the stall check only applies while not already stalled.
   assign stall  = (state_q != StStalled) && (cnt_q >= STALL_CLKS);
   assign accept = edge_det && !stall && (cnt_q >= MIN_PERIOD);

   // Gap when the interval exceeds 1.5x the last normal pitch; 33 bits avoid overflow.
   assign gap_thresh = {1'b0, last_int_q} + {2'b00, last_int_q[31:1]};
   assign gap        = {1'b0, cnt_q} > gap_thresh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StStalled;
         cnt_q      <= 32'd0;
         last_int_q <= 32'd0;
         period_q   <= 32'hFFFF_FFFF;
         idx_q      <= 16'd0;
         phase_q    <= 16'd0;
         width_q    <= QPT;
         trigger_q  <= 1'b0;
         loss_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_int_q <= last_int_d;
         period_q   <= period_d;
         idx_q      <= idx_d;
         phase_q    <= phase_d;
         width_q    <= width_d;
         trigger_q  <= trigger_d;
         loss_q     <= loss_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
      last_int_d = last_int_q;
      period_d   = period_q;
      idx_d      = idx_q;
      phase_d    = phase_q;
      width_d    = width_q;
      trigger_d  = 1'b0;
      loss_d     = 1'b0;

      if (stall) begin
         // Edge in the same cycle is discarded.
         state_d  = StStalled;
         period_d = 32'hFFFF_FFFF;
         idx_d    = 16'd0;
         phase_d  = 16'd0;
         width_d  = QPT;
      end else if (accept) begin
         cnt_d = 32'd1;
         unique case (state_q)
            StStalled: begin
               state_d = StPriming;
            end
            StPriming: begin
               last_int_d = cnt_q;
               state_d    = StSeeking;
            end
            StSeeking: begin
               if (gap) begin
                  state_d   = StSynced;
                  idx_d     = 16'd0;
                  trigger_d = 1'b1;
                  phase_d   = 16'd0;
                  width_d   = QPT;
               end else begin
                  last_int_d = cnt_q;
                  period_d   = cnt_q;
               end
            end
            StSynced: begin
               if (!gap) begin
                  last_int_d = cnt_q;
                  period_d   = cnt_q;
               end
               if (!gap && (idx_q != LAST_IDX)) begin
                  idx_d     = idx_q + 16'd1;
                  trigger_d = 1'b1;
               end else if (gap && (idx_q == LAST_IDX)) begin
                  idx_d     = 16'd0;
                  trigger_d = 1'b1;
               end else begin
                  // Tooth count disagrees with the gap position: drop lock.
                  loss_d  = 1'b1;
                  state_d = StSeeking;
                  idx_d   = 16'd0;
                  phase_d = 16'd0;
                  width_d = QPT;
               end
               if (trigger_d) begin
                  phase_d = idx_d * QPT;
                  width_d = (idx_d == LAST_IDX) ? GAP_WIDTH : QPT;
               end
            end
            default: begin
               state_d = StStalled;
            end
         endcase
      end
   end

   assign bus.trigger               = trigger_q;
   assign bus.sync_loss             = loss_q;
   assign bus.synced                = (state_q == StSynced);
   assign bus.eng_phase             = phase_q;
   assign bus.next_tooth_width      = width_q;
   assign bus.tooth_period          = period_q;
   assign bus.quanta_per_revolution = QPR;

endmodule

// File: tb/tb_crank_decoder.sv
// tb_crank_decoder: directed self-checking bench for crank_decoder on a small 4-1 wheel.
// Expected tooth outputs are queued as teeth are driven and compared when trigger fires.
module tb_crank_decoder;

   localparam int unsigned TT   = 4;
   localparam int unsigned TM   = 1;
   localparam int unsigned QPT  = 100;
   localparam int unsigned MINP = 4;
   localparam int unsigned STL  = 2000;

   typedef struct {
      logic [15:0] phase;
      logic [15:0] width;
      logic [31:0] period;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   int   n_trig;
   int   trig_before;
   exp_t sb_q[$];
   exp_t mon_e;

   crank_if bus ();

   crank_decoder #(
      .TEETH_TOTAL     (TT),
      .TEETH_MISSING   (TM),
      .QUANTA_PER_TOOTH(QPT),
      .MIN_PERIOD      (MINP),
      .STALL_CLKS      (STL)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every trigger must have a queued expectation.
   always @(negedge clk) begin
      if (bus.trigger === 1'b1) begin
         n_trig++;
         check("trigger_expected", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("eng_phase", 32'(bus.eng_phase), 32'(mon_e.phase));
            check("next_tooth_width", 32'(bus.next_tooth_width), 32'(mon_e.width));
            check("tooth_period", bus.tooth_period, mon_e.period);
            check("synced_on_trig", 32'(bus.synced), 32'd1);
            check("no_loss_on_trig", 32'(bus.sync_loss), 32'd0);
            check("qpr", 32'(bus.quanta_per_revolution), 32'd400);
         end
      end
   end

   // Rising edge now, high for 5 clocks, next stimulus wait_after clocks after the edge.
   task automatic tooth(input int wait_after, input bit trig, input logic [15:0] ph,
                        input logic [15:0] wd, input logic [31:0] per);
      exp_t e;
      if (trig) begin
         e.phase  = ph;
         e.width  = wd;
         e.period = per;
         sb_q.push_back(e);
      end
      bus.crank_in = 1'b1;
      repeat (5) @(negedge clk);
      bus.crank_in = 1'b0;
      repeat (wait_after - 5) @(negedge clk);
   endtask

   // Tooth followed by a noise edge 2 clocks later.
   task automatic glitch_tooth(input int wait_after, input logic [15:0] ph,
                               input logic [15:0] wd, input logic [31:0] per);
      exp_t e;
      e.phase  = ph;
      e.width  = wd;
      e.period = per;
      sb_q.push_back(e);
      bus.crank_in = 1'b1;
      @(negedge clk);
      bus.crank_in = 1'b0;
      @(negedge clk);
      bus.crank_in = 1'b1;
      @(negedge clk);
      bus.crank_in = 1'b0;
      repeat (wait_after - 3) @(negedge clk);
   endtask

   initial begin
      n_assert     = 0;
      n_fail       = 0;
      n_trig       = 0;
      rst_n        = 1'b0;
      bus.crank_in = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_trigger", 32'(bus.trigger), 32'd0);
      check("rst_sync_loss", 32'(bus.sync_loss), 32'd0);
      check("rst_synced", 32'(bus.synced), 32'd0);
      check("rst_eng_phase", 32'(bus.eng_phase), 32'd0);
      check("rst_width", 32'(bus.next_tooth_width), 32'd100);
      check("rst_period", bus.tooth_period, 32'hFFFF_FFFF);
      check("rst_qpr", 32'(bus.quanta_per_revolution), 32'd400);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Steady wheel: prime, seek, then 3 locked revolutions
      tooth(100, 1'b0, 16'd0, 16'd0, 32'd0);
      tooth(100, 1'b0, 16'd0, 16'd0, 32'd0);
      tooth(200, 1'b0, 16'd0, 16'd0, 32'd0);
      check("pre_lock_synced", 32'(bus.synced), 32'd0);
      for (int r = 0; r < 3; r++) begin
         tooth(100, 1'b1, 16'd0, 16'd100, 32'd100);
         tooth(100, 1'b1, 16'd100, 16'd100, 32'd100);
         tooth(200, 1'b1, 16'd200, 16'd200, 32'd100);
      end
      check("steady_trig_count", 32'(n_trig), 32'd9);
      check("steady_sb_drained", 32'(sb_q.size()), 32'd0);

      // Latency: gap tooth while synced, trigger after the third clock edge
      begin
         exp_t e;
         e.phase  = 16'd0;
         e.width  = 16'd100;
         e.period = 32'd100;
         sb_q.push_back(e);
      end
      bus.crank_in = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("lat_trig_early", 32'(bus.trigger), 32'd0);
      @(posedge clk);
      #1;
      check("lat_trig", 32'(bus.trigger), 32'd1);
      check("lat_phase", 32'(bus.eng_phase), 32'd0);
      check("lat_width", 32'(bus.next_tooth_width), 32'd100);
      @(negedge clk);
      bus.crank_in = 1'b0;
      repeat (97) @(negedge clk);

      // Glitch after a tooth is rejected
      glitch_tooth(100, 16'd100, 16'd100, 32'd100);
      tooth(200, 1'b1, 16'd200, 16'd200, 32'd100);
      tooth(100, 1'b1, 16'd0, 16'd100, 32'd100);
      tooth(100, 1'b1, 16'd100, 16'd100, 32'd100);
      tooth(100, 1'b1, 16'd200, 16'd200, 32'd100);
      check("glitch_trig_count", 32'(n_trig), 32'd15);

      // Extra tooth where the gap was expected
      trig_before  = n_trig;
      bus.crank_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("extra_sync_loss", 32'(bus.sync_loss), 32'd1);
      check("extra_synced", 32'(bus.synced), 32'd0);
      check("extra_trigger", 32'(bus.trigger), 32'd0);
      @(posedge clk);
      #1;
      check("extra_loss_pulse_end", 32'(bus.sync_loss), 32'd0);
      check("extra_phase", 32'(bus.eng_phase), 32'd0);
      @(negedge clk);
      bus.crank_in = 1'b0;
      repeat (96) @(negedge clk);
      tooth(200, 1'b0, 16'd0, 16'd0, 32'd0);
      check("extra_no_trig", 32'(n_trig - trig_before), 32'd0);
      tooth(100, 1'b1, 16'd0, 16'd100, 32'd100);
      tooth(100, 1'b1, 16'd100, 16'd100, 32'd100);
      tooth(100, 1'b1, 16'd200, 16'd200, 32'd100);
      check("resync_synced", 32'(bus.synced), 32'd1);

      // Stop: still locked just short of the stall limit, stalled just past it
      repeat (1800) @(negedge clk);
      check("pre_stall_synced", 32'(bus.synced), 32'd1);
      repeat (200) @(negedge clk);
      check("stall_synced", 32'(bus.synced), 32'd0);
      check("stall_period", bus.tooth_period, 32'hFFFF_FFFF);
      check("stall_phase", 32'(bus.eng_phase), 32'd0);
      check("stall_width", 32'(bus.next_tooth_width), 32'd100);

      // Restart: two edges then a gap; period not yet measured at first trigger
      trig_before = n_trig;
      tooth(100, 1'b0, 16'd0, 16'd0, 32'd0);
      tooth(200, 1'b0, 16'd0, 16'd0, 32'd0);
      check("restart_no_trig", 32'(n_trig - trig_before), 32'd0);
      tooth(100, 1'b1, 16'd0, 16'd100, 32'hFFFF_FFFF);
      tooth(50, 1'b1, 16'd100, 16'd100, 32'd100);

      // Async reset mid-revolution
      rst_n = 1'b0;
      #1;
      check("arst_trigger", 32'(bus.trigger), 32'd0);
      check("arst_synced", 32'(bus.synced), 32'd0);
      check("arst_sync_loss", 32'(bus.sync_loss), 32'd0);
      check("arst_phase", 32'(bus.eng_phase), 32'd0);
      check("arst_width", 32'(bus.next_tooth_width), 32'd100);
      check("arst_period", bus.tooth_period, 32'hFFFF_FFFF);
      repeat (5) @(negedge clk);
      trig_before = n_trig;
      rst_n       = 1'b1;
      repeat (20) @(negedge clk);
      check("arst_release_no_trig", 32'(n_trig - trig_before), 32'd0);
      check("arst_release_synced", 32'(bus.synced), 32'd0);
      check("final_sb_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
